// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Request/response bundle for the shift sequencer.
//   master : issues requests (op, data, amt) and consumes results
//   slave  : the sequencer itself
// Signals:
//   req_valid/req_ready : request handshake
//   op[1]               : 1 = rotate, 0 = shift
//   op[0]               : 1 = left,   0 = right
//   data, amt           : operand and unsigned shift/rotate amount
//   res_valid/res_ready : result handshake
//   res                 : result
//   busy                : sequencer is not idle
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] data;
  logic [5:0]        amt;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res;
  logic              busy;

  modport master (
    output req_valid, op, data, amt, res_ready,
    input  req_ready, res_valid, res, busy
  );

  modport slave (
    input  req_valid, op, data, amt, res_ready,
    output req_ready, res_valid, res, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Valid/ready front end for the 32-bit barrel shifter. A request is latched,
// run through the shifter once (shift) or twice (rotate = shift one way OR
// shift the other way by 32 - r), and the result is held until consumed.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : shift_sequencer_if.slave (request, result, busy)
//
// Configuration macro:
//   SHIFT_SEQ_ROTATE_EN : when defined, op[1] selects rotate and the second
//                         pass state P2 is built. When undefined, every
//                         request executes as a shift.
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    DONE = 2'd2
`ifdef SHIFT_SEQ_ROTATE_EN
    ,
    P2   = 2'd3
`endif
  } state_t;

  state_t            state;
  logic              left_q;
  logic [5:0]        amt_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] acc;
  logic              res_valid_q;
  logic              busy_q;
  logic              accept;

  // Shifter pass controls and result.
  logic [5:0]        pass_amt;
  logic              pass_left;
  logic [DATA_W-1:0] pass_res;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic              rotate_q;
`endif

  // Combinational by design: a consumer taking the result lets a new
  // request in on the same edge.
  assign bus.req_ready = (state == IDLE) | ((state == DONE) & bus.res_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.res       = acc;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

  // Pass selection: pass 1 uses the requested direction; pass 2 (rotate only)
  // goes the opposite way by 32 - r, which is 32 when r = 0 and so forced to
  // zero, leaving pass 1 (the unshifted operand) as the result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pass_amt  = amt_q;
    pass_left = left_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rotate_q) begin
      if (state == P2) begin
        pass_amt  = 6'd32 - {1'b0, amt_q[4:0]};
        pass_left = ~left_q;
      end else begin
        pass_amt  = {1'b0, amt_q[4:0]};
      end
    end
`endif
    if (pass_amt[5]) begin
      pass_res = '0;                       // amounts >= 32 clear the word
    end else if (pass_left) begin
      pass_res = data_q << pass_amt[4:0];
    end else begin
      pass_res = data_q >> pass_amt[4:0];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= P1;
            acc    <= '0;
            busy_q <= 1'b1;
          end
        end

        P1: begin
          acc <= pass_res;
`ifdef SHIFT_SEQ_ROTATE_EN
          if (rotate_q) begin
            state <= P2;
          end else begin
            state       <= DONE;
            res_valid_q <= 1'b1;
          end
`else
          state       <= DONE;
          res_valid_q <= 1'b1;
`endif
        end

`ifdef SHIFT_SEQ_ROTATE_EN
        P2: begin
          acc         <= acc | pass_res;
          state       <= DONE;
          res_valid_q <= 1'b1;
        end
`endif

        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (accept) begin
              // Result taken and new request accepted on the same edge.
              state <= P1;
              acc   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers.
  // NOTE: pure datapath registers carry no reset; they are always loaded on
  // acceptance before anything reads them.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      left_q <= bus.op[0];
      amt_q  <= bus.amt;
      data_q <= bus.data;
`ifdef SHIFT_SEQ_ROTATE_EN
      rotate_q <= bus.op[1];
`endif
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Directed self-checking bench for shift_sequencer. Expected results are hand
// computed; rotate vectors carry a second expectation for builds without
// SHIFT_SEQ_ROTATE_EN, where they execute as plain shifts.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  shift_sequencer_if #(.DATA_W(32)) bus ();

  shift_sequencer #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle, measure cycles from the acceptance edge
  // (inclusive) until res_valid, check the result, then consume it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [5:0] amt, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    check({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.op        = op;
    bus.data      = data;
    bus.amt       = amt;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
      tick();
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".res"}, bus.res, exp_res);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, ".idle"}, {30'd0, bus.busy, bus.res_valid}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b1;          // request during reset must be ignored
    bus.op        = OP_SLL;
    bus.data      = 32'h1;
    bus.amt       = 6'd1;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    check("rst.res",       bus.res, 32'd0);
    check("rst.res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst.busy",      {31'd0, bus.busy}, 32'd0);
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    check("rst.no_accept", {31'd0, bus.busy}, 32'd0);

    // Shifts and out-of-range amounts.
    run_op("sll_32_2",   OP_SLL, 32'd32, 6'd2,  32'd128, 2);
    run_op("srl_16_3",   OP_SRL, 32'd16, 6'd3,  32'd2,   2);
    run_op("srl_15_10",  OP_SRL, 32'd15, 6'd10, 32'd0,   2);
    run_op("srl_16_32",  OP_SRL, 32'd16, 6'd32, 32'd0,   2);
    run_op("sll_12_63",  OP_SLL, 32'd12, 6'd63, 32'd0,   2);
    run_op("sll_31_0",   OP_SLL, 32'd31, 6'd0,  32'd31,  2);
    run_op("sll_1_31",   OP_SLL, 32'd1,  6'd31, 32'h8000_0000, 2);

    // Rotates (plain shifts without the rotate feature).
    run_op("ror_1_1",    OP_ROR, 32'h0000_0001, 6'd1,
           ROT ? 32'h8000_0000 : 32'h0000_0000, ROT ? 3 : 2);
    run_op("rol_8001_36", OP_ROL, 32'h8000_0001, 6'd36,
           ROT ? 32'h0000_0018 : 32'h0000_0000, ROT ? 3 : 2);
    run_op("ror_dead_32", OP_ROR, 32'hDEAD_BEEF, 6'd32,
           ROT ? 32'hDEAD_BEEF : 32'h0000_0000, ROT ? 3 : 2);
    run_op("rol_8001_4", OP_ROL, 32'h8000_0001, 6'd4,
           ROT ? 32'h0000_0018 : 32'h0000_0010, ROT ? 3 : 2);

    // Backpressure: hold the result for 5 cycles, then take it while a new
    // request enters on the same edge.
    bus.req_valid = 1'b1;
    bus.op        = OP_SRL;
    bus.data      = 32'd16;
    bus.amt       = 6'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("bp.res_valid", {31'd0, bus.res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.res",       bus.res, 32'd2);
      check("bp.req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("bp.busy",      {31'd0, bus.busy}, 32'd1);
    end
    bus.res_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.op        = OP_SLL;
    bus.data      = 32'd1;
    bus.amt       = 6'd4;
    #1;
    check("bp.req_ready_comb", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("bp.p1_valid", {31'd0, bus.res_valid}, 32'd0);
    check("bp.p1_busy",  {31'd0, bus.busy}, 32'd1);
    tick();
    check("bp.new_valid", {31'd0, bus.res_valid}, 32'd1);
    check("bp.new_res",   bus.res, 32'd16);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Reset mid-operation (P2 with rotate, DONE without).
    bus.req_valid = 1'b1;
    bus.op        = OP_ROL;
    bus.data      = 32'hF000_0000;
    bus.amt       = 6'd4;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.res",       bus.res, 32'd0);
    check("mrst.res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("mrst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mrst.busy",      {31'd0, bus.busy}, 32'd0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst.no_stale", {31'd0, bus.res_valid}, 32'd0);
    end
    bus.res_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
